// File: rtl/acquisition_readout.sv
// Readout engine for the acquisition DPRAM: unwraps the circular buffer from
// (trigger - pretrigger) and serializes packed RAM words into a ready/valid stream.
//
// state  | meaning
// IDLE   | waiting for a start; also the landing state after done/abort
// PRIME  | first RAM read issued
// STREAM | lanes serialized from the current word, next word prefetched
module acquisition_readout #(
    parameter int ADC_RAM_ADDRESS_WIDTH     = 14,
    parameter int AXI_SAMPLES_PER_CLOCK     = 8,
    parameter int ADC_WIDTH                 = 14,
    parameter int AXI_SAMPLE_WIDTH          = 16,
    parameter int TRIGGER_DETECTION_LATENCY = 4,
    parameter int COUNT_WIDTH               = 20
) (
    input  logic                                           sysClk,
    input  logic                                           sysReset,
    input  logic                                           sysStart,
    input  logic                                           sysAbort,
    input  logic [ADC_RAM_ADDRESS_WIDTH-1:0]               sysTriggerDpramAddr,
    input  logic [$clog2(AXI_SAMPLES_PER_CLOCK)-1:0]       sysTriggerLocation,
    input  logic [COUNT_WIDTH-1:0]                         sysPretriggerSamples,
    input  logic [COUNT_WIDTH-1:0]                         sysSampleCount,
    output logic                                           sysDpramRdEnable,
    output logic [ADC_RAM_ADDRESS_WIDTH-1:0]               sysDpramRdAddr,
    input  logic [AXI_SAMPLES_PER_CLOCK*ADC_WIDTH-1:0]     sysDpramQ,
    output logic [AXI_SAMPLE_WIDTH-1:0]                    sysTdata,
    output logic                                           sysTvalid,
    input  logic                                           sysTready,
    output logic                                           sysTlast,
    output logic                                           sysBusy,
    output logic                                           sysDone,
    output logic                                           sysError
);

    localparam int AW    = ADC_RAM_ADDRESS_WIDTH;
    localparam int SPC   = AXI_SAMPLES_PER_CLOCK;
    localparam int LW    = $clog2(SPC);
    localparam int SW    = AW + LW;
    localparam int WW    = SPC * ADC_WIDTH;
    localparam int RW    = COUNT_WIDTH + 1;
    localparam int SPW   = COUNT_WIDTH + 2;
    localparam int CMPW  = COUNT_WIDTH + SW + 1;
    localparam logic [CMPW-1:0] CAPACITY = CMPW'(1) << SW;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PRIME  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [WW-1:0]     cur_q, cur_d;
    logic              cur_v_q, cur_v_d;
    logic [LW-1:0]     cur_lane_q, cur_lane_d;
    logic [WW-1:0]     pf_q, pf_d;
    logic              pf_v_q, pf_v_d;
    logic              rd_pend_q, rd_pend_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    logic [RW-1:0]     rd_left_q, rd_left_d;
    logic [RW-1:0]     remaining_q, remaining_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic [AW-1:0]     trig_word;
    logic [SW-1:0]     s0;
    logic [SPW-1:0]    span;
    logic [RW-1:0]     words_total;
    logic              too_big;
    logic              start_ok;
    logic              tvalid;
    logic              beat;
    logic              last_beat;
    logic              pop;
    logic              issue;
    logic [2:0]        occ;
    logic [ADC_WIDTH-1:0] lane_sample;

    // Start sample index, unsigned modulo the buffer capacity
    assign trig_word   = sysTriggerDpramAddr - AW'(TRIGGER_DETECTION_LATENCY);
    assign s0          = {trig_word, sysTriggerLocation} - SW'(sysPretriggerSamples);
    assign span        = SPW'(s0[LW-1:0]) + SPW'(sysSampleCount) + SPW'(SPC - 1);
    assign words_total = RW'(span >> LW);
    assign too_big     = CMPW'(sysSampleCount) > CAPACITY;

    assign start_ok  = sysStart && !sysAbort && (state_q == ST_IDLE);
    assign tvalid    = (state_q == ST_STREAM) && cur_v_q;
    assign beat      = tvalid && sysTready;
    assign last_beat = beat && (remaining_q == RW'(1));
    assign pop       = beat && ((cur_lane_q == LW'(SPC - 1)) || (remaining_q == RW'(1)));

    // Words held or arriving after this cycle's pop; a read may go out if a slot stays free
    assign occ = 3'(cur_v_q) + 3'(pf_v_q) + 3'(rd_pend_q) - 3'(pop);

    always_comb begin
        issue = 1'b0;
        if (!sysAbort) begin
            if (state_q == ST_PRIME) begin
                issue = 1'b1;
            end else if (state_q == ST_STREAM) begin
                issue = (rd_left_q != '0) && !last_beat && (occ <= 3'd1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        cur_v_d     = cur_v_q;
        cur_lane_d  = cur_lane_q;
        pf_d        = pf_q;
        pf_v_d      = pf_v_q;
        rd_pend_d   = issue;
        rd_addr_d   = rd_addr_q;
        rd_left_d   = rd_left_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        error_d     = error_q;

        if (issue) begin
            rd_addr_d = rd_addr_q + AW'(1);
            rd_left_d = rd_left_q - RW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    error_d = too_big;
                    if (!too_big) begin
                        if (sysSampleCount == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d     = ST_PRIME;
                            rd_addr_d   = s0[SW-1:LW];
                            rd_left_d   = words_total;
                            remaining_d = RW'(sysSampleCount);
                            cur_lane_d  = s0[LW-1:0];
                        end
                    end
                end
            end
            ST_PRIME: begin
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (beat) begin
                    remaining_d = remaining_q - RW'(1);
                    cur_lane_d  = pop ? '0 : cur_lane_q + LW'(1);
                end
                if (pop) begin
                    cur_v_d = pf_v_q;
                    if (pf_v_q) begin
                        cur_d  = pf_q;
                        pf_v_d = 1'b0;
                    end
                end
                // Returning read data fills the first free slot of the two-word buffer
                if (rd_pend_q) begin
                    if (!cur_v_d) begin
                        cur_d   = sysDpramQ;
                        cur_v_d = 1'b1;
                    end else begin
                        pf_d   = sysDpramQ;
                        pf_v_d = 1'b1;
                    end
                end
                if (last_beat) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    cur_v_d = 1'b0;
                    pf_v_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (sysAbort) begin
            state_d   = ST_IDLE;
            cur_v_d   = 1'b0;
            pf_v_d    = 1'b0;
            rd_pend_d = 1'b0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            cur_v_q     <= 1'b0;
            cur_lane_q  <= '0;
            pf_q        <= '0;
            pf_v_q      <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
            rd_left_q   <= '0;
            remaining_q <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            cur_v_q     <= cur_v_d;
            cur_lane_q  <= cur_lane_d;
            pf_q        <= pf_d;
            pf_v_q      <= pf_v_d;
            rd_pend_q   <= rd_pend_d;
            rd_addr_q   <= rd_addr_d;
            rd_left_q   <= rd_left_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign lane_sample      = cur_q[cur_lane_q*ADC_WIDTH +: ADC_WIDTH];
    assign sysTdata         = AXI_SAMPLE_WIDTH'(lane_sample) << (AXI_SAMPLE_WIDTH - ADC_WIDTH);
    assign sysTvalid        = tvalid;
    assign sysTlast         = tvalid && (remaining_q == RW'(1));
    assign sysDpramRdEnable = issue;
    assign sysDpramRdAddr   = rd_addr_q;
    assign sysBusy          = (state_q != ST_IDLE);
    assign sysDone          = done_q;
    assign sysError         = error_q;

endmodule
